// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: lets two requesters take turns on one combinational ALU.
// Accepts one operation at a time, drives the registered opcode and operands
// to the ALU, captures the result, and returns it to the requester that
// issued the operation.
// Optional feature macro: ALU_ARB_FIXED_PRIO_EN. When it is defined,
// requester 0 wins every contention; otherwise the two alternate (round-robin).
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [2:0]       r0_op,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [2:0]       r1_op,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic             r0_rsp_valid,
    input  logic             r0_rsp_ready,
    output logic [WIDTH-1:0] r0_rsp_data,
    output logic             r1_rsp_valid,
    input  logic             r1_rsp_ready,
    output logic [WIDTH-1:0] r1_rsp_data,
    output logic [2:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             last_grant
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    state_t           state, state_nxt;
    logic             owner;
    logic             gnt;
    logic             accept;
    logic             rsp_hs;
    logic [WIDTH-1:0] rsp_data;
    req_t             win_req;

    // Pick the winner. This decision uses only the state, last_grant and the
    // request valids, so no response-channel signal reaches a request ready.
    always_comb begin
        gnt = 1'b0;
        if (r0_valid && r1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            gnt = 1'b0;
`else
            gnt = ~last_grant;
`endif
        end else if (r1_valid) begin
            gnt = 1'b1;
        end
        r0_ready = (state == IDLE) && r0_valid && !gnt;
        r1_ready = (state == IDLE) && r1_valid && gnt;
        accept   = r0_ready || r1_ready;
        win_req  = gnt ? req_t'{r1_op, r1_a, r1_b} : req_t'{r0_op, r0_a, r0_b};
    end

    // Next state, plus the response-side outputs, which follow the owner.
    always_comb begin
        state_nxt    = state;
        r0_rsp_valid = (state == RESP) && !owner;
        r1_rsp_valid = (state == RESP) && owner;
        rsp_hs       = (state == RESP) && (owner ? r1_rsp_ready : r0_rsp_ready);
        busy         = (state != IDLE);
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register. A reset in EXEC or RESP drops the operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Load the ALU operands and the owner on acceptance; they hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_opcode <= 3'b000;
            alu_a      <= '0;
            alu_b      <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            alu_opcode <= win_req.op;
            alu_a      <= win_req.a;
            alu_b      <= win_req.b;
            owner      <= gnt;
            last_grant <= gnt;
        end
    end

    // Capture the ALU result at the end of the single EXEC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                rsp_data <= '0;
        else if (state == EXEC) rsp_data <= alu_result;
    end

    assign r0_rsp_data = rsp_data;
    assign r1_rsp_data = rsp_data;

endmodule
